unpacked_mx_split2_buffered: RTL and testbench
==============================================

# unpacked_mx_split2_buffered

Two-way fork for unpacked MX blocks: a vector of IN_SIZE mantissas plus one shared exponent. It replicates each accepted block onto a straight branch and a buffered branch. The buffered branch holds a DEPTH-entry FIFO, so the two consumers can drift apart by up to DEPTH blocks. Full valid/ready backpressure is honoured on both branches. It sits in the attention datapath wherever one MX operand stream feeds two consumers with different latency, e.g. a residual path beside a matmul.

## Interface
- DEPTH, 16: FIFO entries on the buffered branch; minimum 2, any integer.
- MAN_WIDTH, 4: bits per mantissa element.
- EXP_WIDTH, 8: bits of the shared exponent.
- IN_SIZE, 1: mantissa elements per block.
- CW, $clog2(DEPTH+1): occupancy counter width (derived, not overridable).
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mdata_in  in  [MAN_WIDTH-1:0] x IN_SIZE  input block mantissas.
- edata_in  in  EXP_WIDTH  input block exponent.
- data_in_valid  in  1  input block valid.
- data_in_ready  out  1  input block accepted when high with valid.
- fifo_mdata_out / fifo_edata_out  out  as input  buffered-branch block.
- fifo_data_out_valid  out  1  buffered-branch valid.
- fifo_data_out_ready  in  1  buffered-branch ready.
- straight_mdata_out / straight_edata_out  out  as input  straight-branch block, combinational copy of the input.
- straight_data_out_valid  out  1  straight-branch valid.
- straight_data_out_ready  in  1  straight-branch ready.
- fifo_count  out  CW  current FIFO occupancy.

## Operation
- Eager fork. Registered flags done_s and done_f record that the current input block has already been taken by the straight branch or the FIFO.
- straight_data_out_valid = data_in_valid & !done_s.
- push = data_in_valid & !done_f & !full. full = (fifo_count == DEPTH). A full FIFO blocks push even if a pop happens in the same cycle.
- s_ok = done_s | straight_data_out_ready; f_ok = done_f | !full.
- data_in_ready = s_ok & f_ok.
- Input handshake completes on data_in_valid & data_in_ready; both flags clear on that edge.
- Otherwise, when data_in_valid is high, each flag sets if its branch accepted this cycle.
- Flags never set while data_in_valid is low. Upstream must hold the data stable while valid is high and ready is low.
- FIFO storage:
  - circular buffer with wr_ptr/rd_ptr in 0..DEPTH-1, wrapping DEPTH-1 -> 0 (no power-of-2 requirement).
  - pop = fifo_data_out_valid & fifo_data_out_ready.
  - fifo_count += push_into_mem - pop_from_mem; simultaneous push and pop leaves the count unchanged.
- fifo_data_out_valid = (fifo_count != 0); the FIFO output shows mem[rd_ptr].
- Each block is delivered exactly once per branch, in order; no block is lost or duplicated.

## Timing
- Reset values:
  - data_in_ready = straight_data_out_ready (flags 0, FIFO empty, so f_ok = 1).
  - straight_data_out_valid follows data_in_valid.
  - fifo_data_out_valid = 0; fifo_count = 0; pointers = 0; done_s = done_f = 0.
  - FIFO data outputs: 0.
- Straight branch: 0-cycle latency, purely combinational from the input.
- Buffered branch without bypass: the block is visible on the cycle after push; minimum latency 1.
- Reset asserted mid-operation:
  - FIFO contents are discarded, the pointers and count return to 0, and the flags clear, all immediately (asynchronous).
  - A partially forked block is abandoned. Upstream re-presents it after reset.
- Full FIFO with straight ready: the straight branch takes the block and sets done_s. The input stalls until a pop frees a slot, then completes with push only.
- Straight stalled with FIFO not full: the FIFO takes the block once and sets done_f. The input then waits for straight_data_out_ready.

## Configuration
- MX_SPLIT2_BYPASS_EN defined: when fifo_count == 0 and the push condition holds, the input block is driven directly onto the fifo_* outputs with fifo_data_out_valid high in the same cycle.
  - If fifo_data_out_ready is also high, the block is consumed without being written to memory; the count and pointers do not change, and done_f sets or the handshake completes as normal.
  - If fifo_data_out_ready is low, the block is written to memory as normal.
- Not defined: no bypass; buffered-branch latency is always at least 1 cycle.

## Test plan
- DEPTH=4, IN_SIZE=2, both readies high, 6 blocks on consecutive cycles (exp 0x10..0x15):
  - data_in_ready is high every cycle.
  - The straight branch shows each block at 0 latency.
  - The FIFO branch shows exp 0x10..0x15 in order with 1-cycle latency.
  - fifo_count stays ≤1.
- DEPTH=4, fifo_data_out_ready held low, 6 blocks offered:
  - 4 blocks accepted; fifo_count = 4.
  - The 5th is taken by the straight branch; data_in_ready stays low.
  - fifo_data_out_ready raised for 1 cycle: the 5th block completes with push only, and the straight branch does not repeat it.
- straight_data_out_ready low for 3 cycles with one block valid:
  - FIFO count becomes 1 exactly once; data_in_ready is low for 3 cycles.
  - Ready raised: the handshake completes and the flags clear.
- Reset pulse while fifo_count = 3 and done_s = 1: immediately fifo_count = 0 and fifo_data_out_valid = 0, with no clock edge needed. After release, a new block exp 0x2A appears on both branches.
- With MX_SPLIT2_BYPASS_EN, FIFO empty, both readies high, block exp 0x33: fifo_data_out_valid is high in the same cycle with exp 0x33, and fifo_count stays 0.
- Randomized readies with 1000 blocks: scoreboards on both branches match the input order exactly, and fifo_count never exceeds DEPTH.

Source files
------------

// File: rtl/unpacked_mx_split2_buffered_if.sv
// MX block stream: IN_SIZE mantissas plus one shared exponent, valid/ready handshake.
// The master drives data and valid. The slave drives ready.
interface unpacked_mx_split2_buffered_if #(
  parameter int MAN_WIDTH = 4,
  parameter int EXP_WIDTH = 8,
  parameter int IN_SIZE   = 1
);
  logic [MAN_WIDTH-1:0] mdata [IN_SIZE];
  logic [EXP_WIDTH-1:0] edata;
  logic                 valid;
  logic                 ready;

  modport master (output mdata, edata, valid, input ready);
  modport slave  (input mdata, edata, valid, output ready);
endinterface

// File: rtl/unpacked_mx_split2_buffered.sv
// Eager 2-way fork of MX blocks: a 0-latency straight branch, and a DEPTH-entry FIFO branch (latency >= 1, or 0 with MX_SPLIT2_BYPASS_EN).
// Input ready needs both branches to have taken, or be able to take, the block; each branch takes a block exactly once.
module unpacked_mx_split2_buffered #(
  parameter int DEPTH     = 16,
  parameter int MAN_WIDTH = 4,
  parameter int EXP_WIDTH = 8,
  parameter int IN_SIZE   = 1,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  unpacked_mx_split2_buffered_if.slave          data_in,
  unpacked_mx_split2_buffered_if.master         straight_out,
  unpacked_mx_split2_buffered_if.master         fifo_out,
  output logic [CW-1:0]                         fifo_count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [MAN_WIDTH-1:0] mem_m [DEPTH][IN_SIZE];
  logic [EXP_WIDTH-1:0] mem_e [DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic                 done_s, done_f;
  logic                 full, empty, push, s_take, s_ok, f_ok, in_fire;
  logic                 fifo_pop, push_mem, pop_mem, bypass;

  assign full  = (fifo_count == FULL_CNT);
  assign empty = (fifo_count == '0);

  assign straight_out.valid = data_in.valid & ~done_s;
  assign straight_out.edata = data_in.edata;
  always_comb begin
    for (int i = 0; i < IN_SIZE; i++) straight_out.mdata[i] = data_in.mdata[i];
  end

  // A full FIFO refuses the push even when a pop frees a slot on the same edge.
  assign push    = data_in.valid & ~done_f & ~full;
  assign s_take  = straight_out.valid & straight_out.ready;
  assign s_ok    = done_s | straight_out.ready;
  assign f_ok    = done_f | ~full;
  assign data_in.ready = s_ok & f_ok;
  assign in_fire = data_in.valid & data_in.ready;

`ifdef MX_SPLIT2_BYPASS_EN
  assign bypass = push & empty;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_out.valid = ~empty | bypass;
  assign fifo_pop = fifo_out.valid & fifo_out.ready;
  assign pop_mem  = fifo_pop & ~empty;
  // A bypassed block consumed in the same cycle never touches memory.
  assign push_mem = push & ~(bypass & fifo_out.ready);

  always_comb begin
    fifo_out.edata = bypass ? data_in.edata : mem_e[rd_ptr];
    for (int i = 0; i < IN_SIZE; i++)
      fifo_out.mdata[i] = bypass ? data_in.mdata[i] : mem_m[rd_ptr][i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < DEPTH; d++) begin
        mem_e[d] <= '0;
        for (int i = 0; i < IN_SIZE; i++) mem_m[d][i] <= '0;
      end
    end else if (push_mem) begin
      mem_e[wr_ptr] <= data_in.edata;
      for (int i = 0; i < IN_SIZE; i++) mem_m[wr_ptr][i] <= data_in.mdata[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_mem) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop_mem)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      if (push_mem && !pop_mem)      fifo_count <= fifo_count + 1'b1;
      else if (pop_mem && !push_mem) fifo_count <= fifo_count - 1'b1;
    end
  end

  // Flags remember which branch already holds the current block until the input handshake completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_s <= 1'b0;
      done_f <= 1'b0;
    end else if (in_fire) begin
      done_s <= 1'b0;
      done_f <= 1'b0;
    end else if (data_in.valid) begin
      if (s_take) done_s <= 1'b1;
      if (push)   done_f <= 1'b1;
    end
  end
endmodule

// File: tb/tb_unpacked_mx_split2_buffered.sv
// Bench for unpacked_mx_split2_buffered: a queue-based reference model is checked every cycle, plus directed literal checks.
module tb_unpacked_mx_split2_buffered;
  localparam int DEPTH = 4, MW = 4, EW = 8, NS = 2, NR = 1000;
  localparam int CW = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] fifo_count;
  int            total = 0, bad = 0;
  logic [15:0]   s_got[$], f_got[$], mq[$];
  logic          ms = 1'b0, mf = 1'b0;
  logic [15:0]   rblk [NR];

  unpacked_mx_split2_buffered_if #(.MAN_WIDTH(MW), .EXP_WIDTH(EW), .IN_SIZE(NS)) in_if (), st_if (), ff_if ();

  unpacked_mx_split2_buffered #(.DEPTH(DEPTH), .MAN_WIDTH(MW), .EXP_WIDTH(EW), .IN_SIZE(NS)) dut (
    .clk(clk), .rst(rst), .data_in(in_if), .straight_out(st_if), .fifo_out(ff_if), .fifo_count(fifo_count));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] pk(input logic [7:0] e, input logic [3:0] m0, input logic [3:0] m1);
    return {e, m1, m0};
  endfunction

  task automatic drive(input logic [7:0] e);
    in_if.valid    = 1'b1;
    in_if.edata    = e;
    in_if.mdata[0] = e[3:0] ^ 4'ha;
    in_if.mdata[1] = e[7:4] + 4'd1;
  endtask

  // Reference model: FIFO contents as a queue, branch-taken flags, applied once per cycle.
  always @(negedge clk) begin : model
    logic [15:0] cur, e_fd;
    logic full, e_sv, e_push, e_rdy, e_fv, byp;
    if (rst) begin
      mq.delete();
      ms = 1'b0;
      mf = 1'b0;
      chk("rst_in_ready", in_if.ready, st_if.ready);
      chk("rst_fifo_valid", ff_if.valid, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_fifo_edata", ff_if.edata, 0);
    end else begin
      cur    = pk(in_if.edata, in_if.mdata[0], in_if.mdata[1]);
      full   = (mq.size() == DEPTH);
      e_sv   = in_if.valid && !ms;
      e_push = in_if.valid && !mf && !full;
      e_rdy  = (ms || st_if.ready) && (mf || !full);
      e_fv   = (mq.size() != 0);
      e_fd   = e_fv ? mq[0] : 16'h0;
      byp    = 1'b0;
`ifdef MX_SPLIT2_BYPASS_EN
      if (mq.size() == 0 && e_push) begin
        e_fv = 1'b1;
        e_fd = cur;
        byp  = 1'b1;
      end
`endif
      chk("m_st_valid", st_if.valid, e_sv);
      chk("m_in_ready", in_if.ready, e_rdy);
      chk("m_fifo_valid", ff_if.valid, e_fv);
      chk("m_count", fifo_count, mq.size());
      chk("m_count_le_depth", fifo_count <= DEPTH, 1);
      if (e_sv) chk("m_st_data", pk(st_if.edata, st_if.mdata[0], st_if.mdata[1]), cur);
      if (e_fv) chk("m_fifo_data", pk(ff_if.edata, ff_if.mdata[0], ff_if.mdata[1]), e_fd);
      if (byp) begin
        if (!ff_if.ready) mq.push_back(cur);
      end else begin
        if (e_fv && ff_if.ready) void'(mq.pop_front());
        if (e_push) mq.push_back(cur);
      end
      if (in_if.valid && e_rdy) begin
        ms = 1'b0;
        mf = 1'b0;
      end else if (in_if.valid) begin
        if (e_sv && st_if.ready) ms = 1'b1;
        if (e_push) mf = 1'b1;
      end
    end
  end

  always @(negedge clk) begin : monitor
    if (!rst) begin
      if (st_if.valid && st_if.ready) s_got.push_back(pk(st_if.edata, st_if.mdata[0], st_if.mdata[1]));
      if (ff_if.valid && ff_if.ready) f_got.push_back(pk(ff_if.edata, ff_if.mdata[0], ff_if.mdata[1]));
    end
  end

  task automatic send(input logic [7:0] e);
    int n = 0;
    @(posedge clk); #1;
    drive(e);
    @(negedge clk);
    while (!in_if.ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("send_timeout", n < 100, 1);
  endtask

  task automatic drain();
    int n = 0;
    @(posedge clk); #1;
    in_if.valid = 1'b0;
    ff_if.ready = 1'b1;
    while (fifo_count != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", n < 50, 1);
  endtask

  task automatic clear_sb();
    s_got.delete();
    f_got.delete();
  endtask

  initial begin
    in_if.valid = 1'b0;
    in_if.edata = '0;
    in_if.mdata[0] = '0;
    in_if.mdata[1] = '0;
    st_if.ready = 1'b1;
    ff_if.ready = 1'b0;

    // Reset values
    #12;
    chk("t0_in_ready_hi", in_if.ready, 1);
    chk("t0_count", fifo_count, 0);
    chk("t0_fifo_valid", ff_if.valid, 0);
    st_if.ready = 1'b0;
    #1;
    chk("t0_in_ready_lo", in_if.ready, 0);
    st_if.ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Both readies high, six back-to-back blocks
    clear_sb();
    ff_if.ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      drive(8'h10 + 8'(k));
      @(negedge clk);
      chk("t1_in_ready", in_if.ready, 1);
      chk("t1_count_le1", fifo_count <= 1, 1);
`ifndef MX_SPLIT2_BYPASS_EN
      if (k > 0) chk("t1_fifo_lat1", ff_if.edata, 8'h10 + k - 1);
`endif
    end
    drain();
    chk("t1_f_size", f_got.size(), 6);
    chk("t1_s_size", s_got.size(), 6);
    for (int k = 0; k < 6 && k < f_got.size(); k++) chk("t1_f_order", f_got[k][15:8], 8'h10 + k);

    // Buffered branch stalled until full
    clear_sb();
    ff_if.ready = 1'b0;
    st_if.ready = 1'b1;
    for (int k = 0; k < 4; k++) send(8'h20 + 8'(k));
    @(posedge clk); #1;
    drive(8'h24);
    @(negedge clk);
    chk("t2_count4", fifo_count, 4);
    chk("t2_st_take", st_if.valid, 1);
    chk("t2_rdy_lo_a", in_if.ready, 0);
    @(negedge clk);
    chk("t2_st_done", st_if.valid, 0);
    chk("t2_rdy_lo_b", in_if.ready, 0);
    @(posedge clk); #1;
    ff_if.ready = 1'b1;
    @(negedge clk);
    chk("t2_full_pop_rdy", in_if.ready, 0);
    chk("t2_pop_edata", ff_if.edata, 8'h20);
    @(posedge clk); #1;
    ff_if.ready = 1'b0;
    @(negedge clk);
    chk("t2_count3", fifo_count, 3);
    chk("t2_push_only_rdy", in_if.ready, 1);
    chk("t2_no_repeat", st_if.valid, 0);
    @(posedge clk); #1;
    in_if.valid = 1'b0;
    @(negedge clk);
    chk("t2_count4_again", fifo_count, 4);
    drain();
    chk("t2_s_size", s_got.size(), 5);
    chk("t2_f_size", f_got.size(), 5);
    for (int k = 0; k < 5 && k < f_got.size(); k++) chk("t2_f_order", f_got[k][15:8], 8'h20 + k);
    for (int k = 0; k < 5 && k < s_got.size(); k++) chk("t2_s_order", s_got[k][15:8], 8'h20 + k);

    // Straight branch stalled, FIFO takes the block once
    clear_sb();
    ff_if.ready = 1'b0;
    st_if.ready = 1'b0;
    @(posedge clk); #1;
    drive(8'h30);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_rdy_lo", in_if.ready, 0);
    end
    chk("t3_count1", fifo_count, 1);
    @(posedge clk); #1;
    st_if.ready = 1'b1;
    @(negedge clk);
    chk("t3_rdy_hi", in_if.ready, 1);
    chk("t3_count_still1", fifo_count, 1);
    @(posedge clk); #1;
    drive(8'h31);
    @(negedge clk);
    chk("t3_flags_clear_sv", st_if.valid, 1);
    chk("t3_next_rdy", in_if.ready, 1);
    @(posedge clk); #1;
    in_if.valid = 1'b0;
    @(negedge clk);
    chk("t3_count2", fifo_count, 2);
    drain();
    chk("t3_f_size", f_got.size(), 2);
    chk("t3_s_size", s_got.size(), 2);

    // Asynchronous reset with count 3 and done_s set
    clear_sb();
    ff_if.ready = 1'b0;
    st_if.ready = 1'b1;
    for (int k = 0; k < 4; k++) send(8'h40 + 8'(k));
    @(posedge clk); #1;
    drive(8'h44);
    @(negedge clk);
    chk("t4_st_take", st_if.valid, 1);
    @(posedge clk); #1;
    ff_if.ready = 1'b1;
    @(negedge clk);
    chk("t4_full_rdy", in_if.ready, 0);
    @(posedge clk); #1;
    ff_if.ready = 1'b0;
    @(negedge clk);
    chk("t4_count3", fifo_count, 3);
    chk("t4_done_s", st_if.valid, 0);
    #2;
    rst = 1'b1;
    in_if.valid = 1'b0;
    #1;
    chk("t4_async_count", fifo_count, 0);
    chk("t4_async_fvalid", ff_if.valid, 0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    ff_if.ready = 1'b1;
    drive(8'h2A);
    #1;
    chk("t4_st_valid", st_if.valid, 1);
    chk("t4_st_edata", st_if.edata, 8'h2A);
`ifdef MX_SPLIT2_BYPASS_EN
    chk("t4_byp_fvalid", ff_if.valid, 1);
    chk("t4_byp_edata", ff_if.edata, 8'h2A);
`endif
    @(posedge clk); #1;
    in_if.valid = 1'b0;
`ifndef MX_SPLIT2_BYPASS_EN
    chk("t4_fifo_valid", ff_if.valid, 1);
    chk("t4_fifo_edata", ff_if.edata, 8'h2A);
`endif
    drain();

`ifdef MX_SPLIT2_BYPASS_EN
    // Bypass on an empty FIFO
    @(posedge clk); #1;
    ff_if.ready = 1'b1;
    st_if.ready = 1'b1;
    drive(8'h33);
    #1;
    chk("t5_byp_valid", ff_if.valid, 1);
    chk("t5_byp_edata", ff_if.edata, 8'h33);
    chk("t5_byp_count", fifo_count, 0);
    @(posedge clk); #1;
    in_if.valid = 1'b0;
    chk("t5_byp_count_after", fifo_count, 0);
`endif

    // Random readies, 1000 blocks
    begin
      int i = 0, cyc = 0;
      clear_sb();
      for (int k = 0; k < NR; k++) rblk[k] = {8'(k), 4'($urandom), 4'($urandom)};
      while (i < NR && cyc < 20000) begin
        @(posedge clk); #1;
        st_if.ready    = ($urandom_range(3) != 0);
        ff_if.ready    = ($urandom_range(2) != 0);
        in_if.valid    = 1'b1;
        in_if.edata    = rblk[i][15:8];
        in_if.mdata[0] = rblk[i][3:0];
        in_if.mdata[1] = rblk[i][7:4];
        @(negedge clk);
        if (in_if.ready) i++;
        cyc++;
      end
      chk("t6_timeout", i, NR);
      st_if.ready = 1'b1;
      drain();
      chk("t6_s_size", s_got.size(), NR);
      chk("t6_f_size", f_got.size(), NR);
      for (int k = 0; k < NR && k < s_got.size(); k++) chk("t6_s_order", s_got[k], rblk[k]);
      for (int k = 0; k < NR && k < f_got.size(); k++) chk("t6_f_order", f_got[k], rblk[k]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
